// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port and a data port. Data accesses normally win; after STARVE_LIMIT
// back-to-back data grants with a fetch waiting, the fetch is served next.
// Every access walks IDLE -> I_BUSY/D_BUSY -> RESP -> IDLE. All outputs are
// flops loaded from next-state values, so mem_valid rises on the grant edge.
// The ready pulse appears in the RESP cycle. Because the arbiter does not
// sample requests in RESP, a requester that drops its request on seeing
// ready is never granted twice.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic [1:0]  d_read_en,
  input  logic [1:0]  d_write_en,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_read_en,
  output logic [1:0]  mem_write_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          mem_valid_q, mem_valid_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [1:0]    mem_read_en_q, mem_read_en_d;
  logic [1:0]    mem_write_en_q, mem_write_en_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          i_ready_q, i_ready_d;
  logic          d_ready_q, d_ready_d;

  logic          d_pending;
  logic          data_wins;

  // Data wins arbitration unless the waiting fetch has already been passed over STARVE_LIMIT times.
  assign d_pending = (d_read_en != 2'b00) || (d_write_en != 2'b00);
  assign data_wins = d_pending && (!i_req || (starve_q < LIMIT_C));

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    mem_valid_d    = mem_valid_q;
    mem_addr_d     = mem_addr_q;
    mem_read_en_d  = mem_read_en_q;
    mem_write_en_d = mem_write_en_q;
    mem_wdata_d    = mem_wdata_q;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;
    i_ready_d      = 1'b0;
    d_ready_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_wins) begin
          state_d     = D_BUSY;
          mem_valid_d = 1'b1;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // A combined read+write request is carried out as the write alone.
          if (d_write_en != 2'b00) begin
            mem_write_en_d = d_write_en;
            mem_read_en_d  = 2'b00;
          end else begin
            mem_write_en_d = 2'b00;
            mem_read_en_d  = d_read_en;
          end
          // data_wins already guarantees starve_q < LIMIT_C when i_req is set.
          if (i_req) begin
            starve_d = starve_q + ONE_C;
          end else begin
            starve_d = {CW{1'b0}};
          end
        end else if (i_req) begin
          state_d        = I_BUSY;
          mem_valid_d    = 1'b1;
          mem_addr_d     = i_addr;
          mem_read_en_d  = 2'b11;
          mem_write_en_d = 2'b00;
          starve_d       = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end

      I_BUSY, D_BUSY: begin
        if (mem_ack) begin
          state_d        = RESP;
          mem_valid_d    = 1'b0;
          mem_read_en_d  = 2'b00;
          mem_write_en_d = 2'b00;
          if (state_q == I_BUSY) begin
            i_rdata_d = mem_rdata;
            i_ready_d = 1'b1;
          end else begin
            d_ready_d = 1'b1;
            // Only loads refresh d_rdata; stores leave the last load value visible.
            if (mem_read_en_q != 2'b00) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else begin
          state_d = state_q;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d        = IDLE;
        mem_valid_d    = 1'b0;
        mem_read_en_d  = 2'b00;
        mem_write_en_d = 2'b00;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      starve_q       <= {CW{1'b0}};
      mem_valid_q    <= 1'b0;
      mem_addr_q     <= 32'h0000_0000;
      mem_read_en_q  <= 2'b00;
      mem_write_en_q <= 2'b00;
      mem_wdata_q    <= 32'h0000_0000;
      i_rdata_q      <= 32'h0000_0000;
      d_rdata_q      <= 32'h0000_0000;
      i_ready_q      <= 1'b0;
      d_ready_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      mem_valid_q    <= mem_valid_d;
      mem_addr_q     <= mem_addr_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_write_en_q <= mem_write_en_d;
      mem_wdata_q    <= mem_wdata_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
      i_ready_q      <= i_ready_d;
      d_ready_q      <= d_ready_d;
    end
  end

  assign mem_valid    = mem_valid_q;
  assign mem_addr     = mem_addr_q;
  assign mem_read_en  = mem_read_en_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_wdata    = mem_wdata_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign i_ready      = i_ready_q;
  assign d_ready      = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. A transaction-level model
// predicts every output each cycle and is compared on the falling edge;
// hand-computed literals pin the key scenarios.
module tb_mem_arbiter;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic [1:0]  d_read_en;
  logic [1:0]  d_write_en;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [1:0]  mem_read_en;
  logic [1:0]  mem_write_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        auto_ack;
  logic        stray_ack;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory responder configuration.
  bit mem_auto = 1'b1;
  int wait_cfg = 0;
  int wcnt     = 0;

  always #5 clk = ~clk;

  assign mem_ack = auto_ack | stray_ack;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_ready     (i_ready),
    .d_read_en   (d_read_en),
    .d_write_en  (d_write_en),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ready     (d_ready),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_read_en (mem_read_en),
    .mem_write_en(mem_write_en),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  task automatic check(input string name, input logic [134:0] got, input logic [134:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory responder: acks after wait_cfg cycles of mem_valid; data derived from the address.
  initial begin
    auto_ack  = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_auto && mem_valid === 1'b1) begin
        mem_rdata = (mem_addr == 32'h100) ? 32'h0050_0093 : (mem_addr ^ 32'hDEAD_0000);
        if (wcnt >= wait_cfg) begin
          auto_ack = 1'b1;
          wcnt     = 0;
        end else begin
          auto_ack = 1'b0;
          wcnt++;
        end
      end else begin
        auto_ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  // Transaction-level model: who owns the memory, whether the answer is being
  // returned, and how often the fetch has been passed over.
  int          m_owner = 0;   // 0 free, 1 instruction, 2 data
  bit          m_resp  = 1'b0;
  int          m_starve = 0;
  bit          m_is_read = 1'b0;
  bit          m_primed = 1'b0;
  logic        e_valid = 1'b0, e_iready = 1'b0, e_dready = 1'b0;
  logic [1:0]  e_ren = 2'b00, e_wen = 2'b00;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, e_irdata = 32'h0, e_drdata = 32'h0;

  // Compare DUT with the prediction for the last edge, then predict the next edge.
  always @(negedge clk) begin
    if (m_primed)
      check("cycle_outputs",
            {i_ready, d_ready, mem_valid, mem_read_en, mem_write_en, mem_addr, mem_wdata, i_rdata, d_rdata},
            {e_iready, e_dready, e_valid, e_ren, e_wen, e_addr, e_wdata, e_irdata, e_drdata});
    if (rst) begin
      m_owner = 0; m_resp = 1'b0; m_starve = 0; m_is_read = 1'b0;
      e_valid = 1'b0; e_iready = 1'b0; e_dready = 1'b0; e_ren = 2'b00; e_wen = 2'b00;
      e_addr = 32'h0; e_wdata = 32'h0; e_irdata = 32'h0; e_drdata = 32'h0;
    end else if (m_owner != 0 && !m_resp) begin
      if (mem_ack) begin
        m_resp = 1'b1; e_valid = 1'b0; e_ren = 2'b00; e_wen = 2'b00;
        if (m_owner == 1) begin
          e_irdata = mem_rdata; e_iready = 1'b1;
        end else begin
          e_dready = 1'b1;
          if (m_is_read) e_drdata = mem_rdata;
        end
      end
    end else if (m_resp) begin
      m_resp = 1'b0; m_owner = 0; e_iready = 1'b0; e_dready = 1'b0;
    end else begin
      if ((d_read_en != 2'b00 || d_write_en != 2'b00) && !(i_req && m_starve >= LIMIT)) begin
        m_owner = 2; e_valid = 1'b1; e_addr = d_addr; e_wdata = d_wdata; e_wen = d_write_en;
        e_ren = (d_write_en != 2'b00) ? 2'b00 : d_read_en;
        m_is_read = (e_ren != 2'b00);
        m_starve = i_req ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
      end else if (i_req) begin
        m_owner = 1; e_valid = 1'b1; e_addr = i_addr; e_ren = 2'b11; e_wen = 2'b00; m_starve = 0;
      end
    end
    m_primed = 1'b1;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Directed scenarios.
  initial begin
    int          lat, vcnt, rcnt;
    bit          moved, pv;
    logic [31:0] a0, rd;
    string       glog;

    rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_read_en = 2'b00; d_write_en = 2'b00;
    d_addr = 32'h0; d_wdata = 32'h0; stray_ack = 1'b0;
    step(2);
    lit("rst_strobes", {mem_valid, i_ready, d_ready, mem_read_en, mem_write_en}, 64'h0);
    lit("rst_addr_data", {mem_addr, mem_wdata}, 64'h0);
    lit("rst_rdata", {i_rdata, d_rdata}, 64'h0);
    rst = 1'b0;
    step(1);

    // Zero-wait fetch: grant edge, ack edge, ready in the following cycle.
    i_req = 1'b1; i_addr = 32'h100; lat = 99; rd = 32'h0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 0) lit("i_grant", {mem_valid, mem_read_en, mem_write_en, mem_addr}, {1'b1, 2'b11, 2'b00, 32'h100});
      if (i_ready === 1'b1) begin
        lat = k + 1; rd = i_rdata; i_req = 1'b0;
        break;
      end
    end
    lit("i_ready_edges", lat, 2);
    lit("i_rdata_val", rd, 32'h0050_0093);
    step(1);
    lit("i_ready_one_cycle", i_ready, 1'b0);
    step(1);

    // Contention: both ports held; expect three data grants per fetch.
    i_req = 1'b1; i_addr = 32'h100; d_read_en = 2'b11; d_addr = 32'h200;
    glog = ""; pv = mem_valid;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (mem_valid && !pv) begin
        if (mem_addr == 32'h100) glog = {glog, "I"};
        else glog = {glog, "D"};
      end
      pv = mem_valid;
      if (glog.len() == 8) begin
        i_req = 1'b0; d_read_en = 2'b00;
        break;
      end
    end
    n_checks++;
    if (glog == "DDDIDDDI") n_pass++;
    else $display("FAIL grant_order got %s expected DDDIDDDI", glog);
    step(3);

    // Five wait states on a half-word read.
    wait_cfg = 5; d_read_en = 2'b10; d_addr = 32'h302;
    vcnt = 0; rcnt = 0; moved = 1'b0; a0 = 32'h0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (mem_valid) begin
        vcnt++;
        if (vcnt == 1) begin
          a0 = mem_addr; d_read_en = 2'b00;
        end else if (mem_addr !== a0) begin
          moved = 1'b1;
        end
      end
      if (d_ready) rcnt++;
    end
    lit("wait_valid_cycles", vcnt, 6);
    lit("wait_addr_stable", moved, 1'b0);
    lit("wait_addr", a0, 32'h302);
    lit("wait_d_ready_pulses", rcnt, 1);
    lit("wait_d_rdata", d_rdata, 32'hDEAD_0302);
    wait_cfg = 0;

    // Write with a simultaneous read request: only the write reaches memory.
    d_write_en = 2'b01; d_read_en = 2'b11; d_addr = 32'h203; d_wdata = 32'hAB;
    step(1);
    lit("wr_strobe", {mem_valid, mem_write_en, mem_read_en}, {1'b1, 2'b01, 2'b00});
    lit("wr_addr_data", {mem_addr, mem_wdata}, {32'h203, 32'hAB});
    d_write_en = 2'b00; d_read_en = 2'b00;
    rcnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (d_ready) rcnt++;
    end
    lit("wr_d_ready_pulses", rcnt, 1);
    lit("wr_d_rdata_kept", d_rdata, 32'hDEAD_0302);

    // Reset in the middle of a data access, then a stray ack.
    wait_cfg = 50; d_read_en = 2'b11; d_addr = 32'h400;
    step(1);
    lit("abort_busy", {mem_valid, mem_addr}, {1'b1, 32'h400});
    d_read_en = 2'b00;
    step(1);
    rst = 1'b1;
    step(1);
    lit("abort_valid_low", {mem_valid, i_ready, d_ready}, 64'h0);
    rst = 1'b0; mem_auto = 1'b0; wait_cfg = 0; stray_ack = 1'b1;
    rcnt = 0; vcnt = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      if (k == 1) stray_ack = 1'b0;
      if (i_ready || d_ready) rcnt++;
      if (mem_valid) vcnt++;
    end
    lit("stray_no_ready", rcnt, 0);
    lit("stray_no_valid", vcnt, 0);
    mem_auto = 1'b1;

    // Arbiter still serves requests after the abort.
    i_req = 1'b1; i_addr = 32'h180; rd = 32'h0; lat = 99;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (i_ready === 1'b1) begin
        lat = k + 1; rd = i_rdata; i_req = 1'b0;
        break;
      end
    end
    lit("recover_edges", lat, 2);
    lit("recover_i_rdata", rd, 32'hDEAD_0180);
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
